dmem_ls_sequencer: RTL and testbench

//  FSM sequencing the DataMemory + RegisterFile datapath for LOAD and STORE.

---
 rtl/dmem_ctrl_pkg.sv | 24 ++
 rtl/dmem_ls_sequencer_if.sv | 14 +
 rtl/dmem_ls_sequencer.sv | 69 ++++++
 tb/tb_dmem_ls_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: state encoding, opcodes and instruction field helpers for dmem_ls_sequencer
package dmem_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LD_ADDR, LD_WB, ST_WR, DONE, ERR} state_t;
  localparam logic [3:0] OPC_LOAD = 4'b0010;
  localparam logic [3:0] OPC_STORE = 4'b0001;
  localparam int OPC_HI = 15, OPC_LO = 12;
  localparam int LD_ADDR_HI = 11, LD_ADDR_LO = 4, LD_RD_HI = 3, LD_RD_LO = 0;
  localparam int ST_RS_HI = 11, ST_RS_LO = 8, ST_ADDR_HI = 7, ST_ADDR_LO = 0;
  function automatic logic [3:0] opcode(logic [15:0] ir);
    return ir[OPC_HI:OPC_LO];
  endfunction
  function automatic logic [7:0] ld_addr(logic [15:0] ir);
    return ir[LD_ADDR_HI:LD_ADDR_LO];
  endfunction
  function automatic logic [3:0] ld_rd(logic [15:0] ir);
    return ir[LD_RD_HI:LD_RD_LO];
  endfunction
  function automatic logic [3:0] st_rs(logic [15:0] ir);
    return ir[ST_RS_HI:ST_RS_LO];
  endfunction
  function automatic logic [7:0] st_addr(logic [15:0] ir);
    return ir[ST_ADDR_HI:ST_ADDR_LO];
  endfunction
endpackage

// File: rtl/dmem_ls_sequencer_if.sv
// dmem_ls_sequencer_if: instruction handshake plus DataMemory/RegisterFile control bus
interface dmem_ls_sequencer_if;
  logic [15:0] Instr;
  logic        Instr_valid;
  logic        Instr_ready;
  logic [7:0]  D_Addr;
  logic        D_wr;
  logic        RF_W_en;
  logic [3:0]  RF_W_addr;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  modport master (output Instr, Instr_valid, input Instr_ready, D_Addr, D_wr, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr);
  modport slave (input Instr, Instr_valid, output Instr_ready, D_Addr, D_wr, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr);
endinterface

// File: rtl/dmem_ls_sequencer.sv
// dmem_ls_sequencer: Moore FSM sequencing LOAD/STORE through DataMemory and RegisterFile
module dmem_ls_sequencer
  import dmem_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int CNT_W = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  dmem_ls_sequencer_if.slave bus,
  input  logic [3:0]         Obs_addr,
  input  logic               Cnt_clr,
  output logic               Busy,
  output logic               Done,
  output logic               Illegal,
  output logic [CNT_W-1:0]   Load_cnt,
  output logic [CNT_W-1:0]   Store_cnt
);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
  state_t state, state_nx;
  logic [15:0] ir;
  logic [LAT_W-1:0] lat;
  logic [7:0] d_addr_q;
  logic accept;
  assign accept = bus.Instr_valid && bus.Instr_ready;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = opcode(bus.Instr) == OPC_LOAD ? LD_ADDR :
                                      opcode(bus.Instr) == OPC_STORE ? ST_WR : ERR;
      LD_ADDR: if (lat == LAT_LAST) state_nx = LD_WB;
      LD_WB:   state_nx = DONE;
      ST_WR:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // D_Addr keeps its last driven value outside the memory-access states
  always_comb begin
    bus.Instr_ready = state == IDLE;
    Busy = state != IDLE;
    Done = state == DONE || state == ERR;
    Illegal = state == ERR;
    bus.D_wr = state == ST_WR;
    bus.RF_W_en = state == LD_WB;
    bus.RF_W_addr = state == LD_WB ? ld_rd(ir) : '0;
    bus.RF_Ra_addr = state == ST_WR ? st_rs(ir) : '0;
    bus.D_Addr = state == ST_WR ? st_addr(ir) :
                 (state == LD_ADDR || state == LD_WB) ? ld_addr(ir) : d_addr_q;
    bus.RF_Rb_addr = Obs_addr;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      ir <= '0;
      lat <= '0;
      d_addr_q <= '0;
      Load_cnt <= '0;
      Store_cnt <= '0;
    end else begin
      if (accept) ir <= bus.Instr;
      lat <= state == LD_ADDR && lat != LAT_LAST ? lat + LAT_W'(1) : '0;
      d_addr_q <= bus.D_Addr;
      Load_cnt <= Cnt_clr ? '0 : state == DONE && opcode(ir) == OPC_LOAD ? Load_cnt + CNT_W'(1) : Load_cnt;
      Store_cnt <= Cnt_clr ? '0 : state == DONE && opcode(ir) == OPC_STORE ? Store_cnt + CNT_W'(1) : Store_cnt;
    end
endmodule

// File: tb/tb_dmem_ls_sequencer.sv
// tb_dmem_ls_sequencer: directed LOAD/STORE sequences checked against a per-instruction timeline model
module tb_dmem_ls_sequencer;
  localparam int LAT = 1;
  logic Clk = 0, rst_n = 0, rst3_n = 0;
  logic [3:0] obs = 4'd7;
  logic clr = 0, clr3 = 0;
  logic busy, done, ill, busy3, done3, ill3;
  logic [7:0] ld_cnt, st_cnt, ld3, st3;
  logic [7:0] mem [256], rf [16], mem3 [256], rf3 [16];
  int cyc = 0, wen_cnt = 0, dwr_cnt = 0, wen3_cnt = 0;
  int checks = 0, errors = 0;
  dmem_ls_sequencer_if bus();
  dmem_ls_sequencer_if bus3();
  dmem_ls_sequencer #(.RD_LAT(LAT), .CNT_W(8)) u_dut (
    .Clk(Clk), .Reset_n(rst_n), .bus(bus.slave), .Obs_addr(obs), .Cnt_clr(clr),
    .Busy(busy), .Done(done), .Illegal(ill), .Load_cnt(ld_cnt), .Store_cnt(st_cnt));
  dmem_ls_sequencer #(.RD_LAT(3), .CNT_W(8)) u_dut3 (
    .Clk(Clk), .Reset_n(rst3_n), .bus(bus3.slave), .Obs_addr(obs), .Cnt_clr(clr3),
    .Busy(busy3), .Done(done3), .Illegal(ill3), .Load_cnt(ld3), .Store_cnt(st3));
  always #5 Clk = ~Clk;
  // DataMemory / RegisterFile stand-ins for both instances
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= '0;
        mem3[i] <= '0;
      end
      for (int i = 0; i < 16; i++) begin
        rf[i] <= '0;
        rf3[i] <= '0;
      end
      mem[0] <= 8'd123;
      mem[5] <= 8'd77;
      mem3[0] <= 8'd123;
      mem3[5] <= 8'd77;
    end else begin
      if (bus.D_wr) mem[bus.D_Addr] <= rf[bus.RF_Ra_addr];
      if (bus.RF_W_en) rf[bus.RF_W_addr] <= mem[bus.D_Addr];
      if (bus3.D_wr) mem3[bus3.D_Addr] <= rf3[bus3.RF_Ra_addr];
      if (bus3.RF_W_en) rf3[bus3.RF_W_addr] <= mem3[bus3.D_Addr];
      if (bus.RF_W_en) wen_cnt <= wen_cnt + 1;
      if (bus.D_wr) dwr_cnt <= dwr_cnt + 1;
      if (bus3.RF_W_en) wen3_cnt <= wen3_cnt + 1;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  typedef struct packed {
    logic drv; logic [7:0] addr; logic dwr, wen; logic [3:0] wa, ra; logic done, ill; logic [1:0] kind;
  } step_t;
  function automatic step_t mk(logic drv, logic [7:0] addr, logic dwr, logic wen, logic [3:0] wa,
                               logic [3:0] ra, logic done, logic ill, logic [1:0] kind);
    return {drv, addr, dwr, wen, wa, ra, done, ill, kind};
  endfunction
  step_t q[$];
  int exp_ld = 0, exp_st = 0;
  logic [7:0] last_addr = 0;
  // Each accepted instruction expands into the list of cycles it must occupy
  always @(negedge Clk) begin : cmp
    step_t cur;
    logic [15:0] ins;
    if (!rst_n) begin
      q.delete();
      exp_ld = 0;
      exp_st = 0;
      last_addr = 0;
    end
    cur = q.size() != 0 ? q[0] : '0;
    chk("ready", bus.Instr_ready, q.size() == 0);
    chk("busy", busy, q.size() != 0);
    chk("done", done, cur.done);
    chk("illegal", ill, cur.ill);
    chk("d_wr", bus.D_wr, cur.dwr);
    chk("rf_w_en", bus.RF_W_en, cur.wen);
    if (cur.wen) chk("rf_w_addr", bus.RF_W_addr, cur.wa);
    if (cur.dwr) chk("rf_ra_addr", bus.RF_Ra_addr, cur.ra);
    chk("d_addr", bus.D_Addr, cur.drv ? cur.addr : last_addr);
    chk("rf_rb_addr", bus.RF_Rb_addr, obs);
    chk("load_cnt", ld_cnt, exp_ld);
    chk("store_cnt", st_cnt, exp_st);
    if (cur.drv) last_addr = cur.addr;
    if (cur.done && cur.kind == 2'd1) exp_ld = (exp_ld + 1) % 256;
    if (cur.done && cur.kind == 2'd2) exp_st = (exp_st + 1) % 256;
    if (clr) begin
      exp_ld = 0;
      exp_st = 0;
    end
    if (q.size() != 0) void'(q.pop_front());
    else if (bus.Instr_valid && rst_n) begin
      ins = bus.Instr;
      if (ins[15:12] == 4'b0010) begin
        for (int i = 0; i < LAT; i++) q.push_back(mk(1, ins[11:4], 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, ins[11:4], 0, 1, ins[3:0], 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'd1));
      end else if (ins[15:12] == 4'b0001) begin
        q.push_back(mk(1, ins[7:0], 1, 0, 0, ins[11:8], 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'd2));
      end else q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
    end
  end
  task automatic issue(input logic [15:0] ins, output int acc);
    bit ok = 0;
    @(posedge Clk);
    #1 bus.Instr = ins;
    bus.Instr_valid = 1;
    acc = -1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clk);
      if (bus.Instr_ready) begin
        ok = 1;
        acc = cyc;
      end
    end
    if (!ok) chk("issue_timeout", 0, 1);
    @(posedge Clk);
    #1 bus.Instr_valid = 0;
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clk);
      ok = bus.Instr_ready;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int a, a1, a2, d1, w0, dw0;
    bit ok;
    bus.Instr = '0;
    bus.Instr_valid = 0;
    bus3.Instr = '0;
    bus3.Instr_valid = 0;
    @(negedge Clk);
    chk("rst_ready", bus.Instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_d_addr", bus.D_Addr, 0);
    chk("rst_w_addr", bus.RF_W_addr, 0);
    repeat (2) @(posedge Clk);
    #1 rst_n = 1;
    rst3_n = 1;
    // LOAD R3 <- mem[0]
    issue(16'h2003, a);
    @(negedge Clk);
    chk("t1_d_addr", bus.D_Addr, 0);
    @(negedge Clk);
    chk("t1_wen", bus.RF_W_en, 1);
    chk("t1_waddr", bus.RF_W_addr, 3);
    @(negedge Clk);
    chk("t1_done", done, 1);
    chk("t1_done_cycle", cyc, a + 3);
    @(negedge Clk);
    chk("t1_r3", rf[3], 123);
    chk("t1_ldcnt", ld_cnt, 1);
    // LOAD R2 <- mem[5], then STORE mem[9] <- R2
    obs = 4'hA;
    issue(16'h2052, a);
    wait_idle();
    dw0 = dwr_cnt;
    issue(16'h1209, a);
    @(negedge Clk);
    chk("t2_dwr", bus.D_wr, 1);
    chk("t2_daddr", bus.D_Addr, 9);
    chk("t2_ra", bus.RF_Ra_addr, 2);
    @(negedge Clk);
    chk("t2_done", done, 1);
    chk("t2_done_cycle", cyc, a + 2);
    @(negedge Clk);
    chk("t2_mem9", mem[9], 77);
    chk("t2_stcnt", st_cnt, 1);
    chk("t2_dwr_pulses", dwr_cnt - dw0, 1);
    // illegal opcode
    w0 = wen_cnt;
    dw0 = dwr_cnt;
    issue(16'h7000, a);
    @(negedge Clk);
    chk("t3_done", done, 1);
    chk("t3_illegal", ill, 1);
    @(negedge Clk);
    chk("t3_ldcnt", ld_cnt, 2);
    chk("t3_stcnt", st_cnt, 1);
    chk("t3_no_strobes", (wen_cnt - w0) + (dwr_cnt - dw0), 0);
    // two LOADs with Instr_valid held
    w0 = wen_cnt;
    @(posedge Clk);
    #1 bus.Instr = 16'h2003;
    bus.Instr_valid = 1;
    a1 = -1;
    for (int i = 0; i < 20 && a1 < 0; i++) begin
      @(negedge Clk);
      if (bus.Instr_ready) a1 = cyc;
    end
    @(posedge Clk);
    #1 bus.Instr = 16'h2052;
    d1 = -1;
    a2 = -1;
    for (int i = 0; i < 20 && a2 < 0; i++) begin
      @(negedge Clk);
      if (busy) chk("t5_ready_low", bus.Instr_ready, 0);
      if (done && d1 < 0) d1 = cyc;
      if (bus.Instr_ready) a2 = cyc;
    end
    @(posedge Clk);
    #1 bus.Instr_valid = 0;
    chk("t5_gap", a2, d1 + 1);
    chk("t5_second_accept", a2, a1 + 4);
    wait_idle();
    chk("t5_wen_pulses", wen_cnt - w0, 2);
    chk("t5_ldcnt", ld_cnt, 4);
    // counter wrap
    @(posedge Clk);
    #1 clr = 1;
    @(posedge Clk);
    #1 clr = 0;
    chk("t6_clr_ld", ld_cnt, 0);
    chk("t6_clr_st", st_cnt, 0);
    for (int i = 0; i < 256; i++) begin
      issue(16'h2003, a);
      wait_idle();
      if (i == 254) chk("t6_cnt255", ld_cnt, 255);
    end
    chk("t6_wrap", ld_cnt, 0);
    issue(16'h2003, a);
    wait_idle();
    issue(16'h2003, a);
    wait_idle();
    chk("t6_two", ld_cnt, 2);
    issue(16'h2003, a);
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1 clr = 1;
    chk("t6_done_with_clr", done, 1);
    @(posedge Clk);
    #1 clr = 0;
    chk("t6_clr_wins", ld_cnt, 0);
    // RD_LAT=3 instance: reset in the 2nd LD_ADDR cycle
    @(posedge Clk);
    #1 bus3.Instr = 16'h2003;
    bus3.Instr_valid = 1;
    @(negedge Clk);
    chk("t4_ready", bus3.Instr_ready, 1);
    @(posedge Clk);
    #1 bus3.Instr_valid = 0;
    @(negedge Clk);
    chk("t4_busy", busy3, 1);
    @(negedge Clk);
    chk("t4_busy2", busy3, 1);
    rst3_n = 0;
    #1;
    chk("t4_rst_busy", busy3, 0);
    chk("t4_rst_ready", bus3.Instr_ready, 1);
    chk("t4_rst_wen", bus3.RF_W_en, 0);
    @(negedge Clk);
    rst3_n = 1;
    repeat (6) @(negedge Clk);
    chk("t4_no_wen", wen3_cnt, 0);
    chk("t4_r3", rf3[3], 0);
    chk("t4_ldcnt", ld3, 0);
    chk("t4_idle", busy3, 0);
    chk("t4_rb", bus3.RF_Rb_addr, obs);
    // full RD_LAT=3 load: write-back at accept+4, Done at accept+5
    @(posedge Clk);
    #1 bus3.Instr = 16'h2003;
    bus3.Instr_valid = 1;
    @(negedge Clk);
    chk("t4b_ready", bus3.Instr_ready, 1);
    @(posedge Clk);
    #1 bus3.Instr_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      chk("t4b_wen", bus3.RF_W_en, k == 4);
      chk("t4b_done", done3, k == 5);
      chk("t4b_ill", ill3, 0);
    end
    @(negedge Clk);
    chk("t4b_r3", rf3[3], 123);
    chk("t4b_ldcnt", ld3, 1);
    chk("t4b_stcnt", st3, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
